// File: rtl/demux_stream_scheduler_pkg.sv
// Shared definitions for the demux stream scheduler and its lane picker.
//   N_LANES / SEL_W : lane count and lane-index width
//   state_t         : holding-register occupancy (IDLE = empty, BUSY = word held)
//   MODE_RR/FIXED   : values of the mode input
//   lane_onehot()   : lane index -> one-hot lane mask
package demux_stream_scheduler_pkg;
   localparam int N_LANES = 8;
   localparam int SEL_W   = 3;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   function automatic logic [N_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
      logic [N_LANES-1:0] oh;
      oh = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/demux_rr_pick.sv
// Rotating-priority picker: returns the first set bit of mask, searching
// upward from ptr and wrapping modulo N_LANES.
//   mask : candidate lanes
//   ptr  : highest-priority lane this cycle
//   sel  : chosen lane (equals ptr when nothing is set)
//   any  : at least one lane in mask is set
module demux_rr_pick
   import demux_stream_scheduler_pkg::*;
(
   input  logic [N_LANES-1:0] mask,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   sel,
   output logic               any
);
   logic [SEL_W-1:0] idx;
   logic             found;

   always_comb begin
      sel   = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int i = 0; i < N_LANES; i++) begin
         idx = ptr + SEL_W'(i);   // natural wrap of the 3-bit index
         if (!found && mask[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   assign any = |mask;
endmodule

// File: rtl/demux_stream_scheduler.sv
// Schedules one valid/ready input stream onto eight demux lanes through a
// one-entry holding register. Words go round-robin over enabled lanes
// (mode = 0) or to dest_sel (mode = 1).
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_data    : upstream word, in_ready back-pressure
//   mode, dest_sel      : routing policy, fixed destination
//   lane_en             : lanes allowed to receive new words
//   out_valid/out_data  : one-hot lane valid, shared held word
//   out_ready           : per-lane consumer ready
//   cur_sel             : lane of the held word
//   xfer_cnt            : completed output handshakes (wraps)
module demux_stream_scheduler
   import demux_stream_scheduler_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              mode,
   input  logic [2:0]        dest_sel,
   input  logic [7:0]        lane_en,
   output logic [7:0]        out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic [7:0]        out_ready,
   output logic [2:0]        cur_sel,
   output logic [CNT_W-1:0]  xfer_cnt
);
   state_t           state, state_nxt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_sel, tgt;
   logic             rr_any, tgt_ok;
   logic             ofire, accept;

   demux_rr_pick u_pick (
      .mask (lane_en),
      .ptr  (ptr),
      .sel  (rr_sel),
      .any  (rr_any)
   );

   // Target is recomputed every cycle; the held word's lane is frozen in
   // cur_sel, so mode/dest_sel/lane_en changes only steer the next accept.
   always_comb begin
      tgt    = rr_sel;
      tgt_ok = rr_any;
      if (mode == MODE_FIXED) begin
         tgt    = dest_sel;
         tgt_ok = lane_en[dest_sel];
      end
   end

   assign ofire    = (state == BUSY) && out_ready[cur_sel];
   // Gated by rst_n so upstream sees no ready while reset is held.
   assign in_ready = rst_n && tgt_ok && ((state == IDLE) || ofire);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = BUSY;
         BUSY: if (ofire && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Holding register; a simultaneous drain and accept refills it in place
   // for 1 word/clk throughput.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_data  <= '0;
         cur_sel   <= '0;
         ptr       <= '0;
      end else if (accept) begin
         out_valid <= lane_onehot(tgt);
         out_data  <= in_data;
         cur_sel   <= tgt;
         if (mode == MODE_RR) ptr <= tgt + SEL_W'(1);
      end else if (ofire) begin
         out_valid <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     xfer_cnt <= '0;
      else if (ofire) xfer_cnt <= xfer_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_demux_stream_scheduler.sv
module tb_demux_stream_scheduler;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       mode;
   logic [2:0] dest_sel;
   logic [7:0] lane_en;
   logic [7:0] out_valid;
   logic [7:0] out_data;
   logic [7:0] out_ready;
   logic [2:0] cur_sel;
   logic [15:0] xfer_cnt;

   int tests = 0;
   int fails = 0;

   logic [2:0] exp_d [4];
   logic [2:0] exp_g [8];

   demux_stream_scheduler #(.DATA_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mode      (mode),
      .dest_sel  (dest_sel),
      .lane_en   (lane_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .cur_sel   (cur_sel),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_d = '{3'd2, 3'd5, 3'd7, 3'd2};
      exp_g = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd2};

      // Reset state
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
      dest_sel = '0; lane_en = 8'hFF; out_ready = 8'hFF;
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_cur_sel", cur_sel, 0);
      chk("rst_xfer", xfer_cnt, 0);
      rst_n = 1'b1;
      #1;

      // RR, all lanes, 10 back-to-back words
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_data = 8'h10 + 8'(k);
         chk("rr_in_ready", in_ready, 1);
         tick();
         chk("rr_out_valid", out_valid, 32'(1) << (k % 8));
         chk("rr_out_data", out_data, 8'h10 + 8'(k));
         chk("rr_xfer_run", xfer_cnt, k);
      end
      in_valid = 1'b0;
      tick();
      chk("rr_xfer_10", xfer_cnt, 10);
      chk("rr_idle", out_valid, 0);

      // Reset while holding a word on lane 2 (ptr = 2)
      out_ready = 8'h00; in_valid = 1'b1; in_data = 8'hAA;
      tick();
      chk("mid_busy_ov", out_valid, 8'h04);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_xfer", xfer_cnt, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      out_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h55;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      tick();
      chk("post_rst_lane0", out_valid, 8'h01);
      chk("post_rst_sel", cur_sel, 0);
      chk("post_rst_data", out_data, 8'h55);
      in_valid = 1'b0;
      tick();
      chk("post_rst_xfer", xfer_cnt, 1);

      // RR with sparse mask from ptr = 0
      rst_n = 1'b0; #1; rst_n = 1'b1;
      lane_en = 8'b1010_0100;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 8'h20 + 8'(k);
         tick();
         chk("sparse_sel", cur_sel, exp_d[k]);
         chk("sparse_data", out_data, 8'h20 + 8'(k));
      end
      in_valid = 1'b0;
      tick();
      chk("sparse_xfer", xfer_cnt, 4);

      // Fixed lane 6 stall; dest_sel changed mid-stall steers only the next word
      mode = 1'b1; dest_sel = 3'd6; lane_en = 8'hFF; out_ready = 8'h00;
      in_valid = 1'b1; in_data = 8'h66;
      tick();
      chk("fix_ov", out_valid, 8'h40);
      in_data = 8'h67; dest_sel = 3'd2; out_ready = 8'hBF;
      for (int k = 0; k < 5; k++) begin
         chk("stall_in_ready", in_ready, 0);
         tick();
         chk("stall_ov", out_valid, 8'h40);
         chk("stall_data", out_data, 8'h66);
         chk("stall_xfer", xfer_cnt, 4);
      end
      out_ready = 8'hFF;
      #1;
      chk("release_in_ready", in_ready, 1);
      tick();
      chk("release_ov", out_valid, 8'h04);
      chk("release_data", out_data, 8'h67);
      chk("release_xfer", xfer_cnt, 5);
      in_valid = 1'b0;
      tick();
      chk("fix_xfer", xfer_cnt, 6);

      // Fixed lane disabled, then all lanes disabled in RR
      dest_sel = 3'd3; lane_en = 8'hF7; in_valid = 1'b1; in_data = 8'h33;
      #1;
      chk("dis_in_ready", in_ready, 0);
      tick();
      chk("dis_ov", out_valid, 0);
      chk("dis_xfer", xfer_cnt, 6);
      mode = 1'b0; lane_en = 8'h00;
      #1;
      chk("none_in_ready", in_ready, 0);
      mode = 1'b1; lane_en = 8'hFF;
      #1;
      chk("en_in_ready", in_ready, 1);
      tick();
      chk("en_ov", out_valid, 8'h08);
      chk("en_data", out_data, 8'h33);
      in_valid = 1'b0;
      tick();
      chk("en_xfer", xfer_cnt, 7);

      // Two fixed words to lane 0 (ptr stays 3)
      dest_sel = 3'd0; in_valid = 1'b1; in_data = 8'h01;
      tick();
      in_data = 8'h02;
      tick();
      in_valid = 1'b0;
      tick();
      chk("fix0_xfer", xfer_cnt, 9);

      // Long RR stream brings xfer_cnt to FFFF with the last word on lane 1
      mode = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 65527; i++) begin
         in_data = 8'(i);
         tick();
      end
      chk("long_sel", cur_sel, 1);
      chk("long_ov", out_valid, 8'h02);
      chk("long_data", out_data, 8'hF6);
      chk("long_xfer", xfer_cnt, 16'hFFFF);
      in_valid = 1'b0; out_ready = 8'h00; lane_en = 8'hFD;
      tick();
      chk("cleared_hold_ov", out_valid, 8'h02);
      chk("cleared_hold_xfer", xfer_cnt, 16'hFFFF);
      out_ready = 8'hFF;
      tick();
      chk("wrap_xfer", xfer_cnt, 0);
      chk("wrap_ov", out_valid, 0);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
         tick();
         chk("skip_sel", cur_sel, exp_g[k]);
      end
      in_valid = 1'b0;
      tick();
      chk("skip_xfer", xfer_cnt, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/demux_stream_scheduler.md
Name: demux_stream_scheduler

Overview:
- Sequences a single input data stream onto the 1-to-8 output demux lanes.
- Each word is routed either round-robin over the enabled lanes or to a fixed lane chosen by software.
- A one-entry holding register decouples the input from per-lane backpressure; the valid/ready handshake runs on both sides.
- Sits between an upstream producer and eight lane consumers, as the control wrapper around the demux datapath.

Parameters:
- DATA_W, 8, width of data word.
- CNT_W, 16, width of transferred-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  scheduler can accept a word this cycle.
- mode  in  1  0 = round-robin, 1 = fixed destination.
- dest_sel  in  3  fixed-mode destination lane.
- lane_en  in  8  per-lane enable mask.
- out_valid  out  8  one-hot lane valid; all zero when empty.
- out_data  out  DATA_W  held word, shared by all lanes.
- out_ready  in  8  per-lane consumer ready.
- cur_sel  out  3  lane of the held word.
- xfer_cnt  out  CNT_W  count of completed output handshakes, wraps.

Behaviour:
- Reset values (async on rst_n low):
  - state = IDLE, out_valid = 0, out_data = 0, cur_sel = 0.
  - RR pointer ptr = 0, xfer_cnt = 0.
  - in_ready deasserts combinationally during reset.
- States:
  - IDLE: holding register empty.
  - BUSY: word held, out_valid[cur_sel] = 1.
- Target lane, computed combinationally every cycle:
  - mode = 1: tgt = dest_sel; tgt_ok = lane_en[dest_sel].
  - mode = 0: tgt = first k in order ptr, ptr+1, …, ptr+7 (mod 8) with lane_en[k] = 1; tgt_ok = |lane_en.
- Output handshake: ofire = BUSY && out_ready[cur_sel].
- in_ready = tgt_ok && (IDLE || ofire). Accept occurs when in_valid && in_ready.
- On accept:
  - out_data <= in_data, cur_sel <= tgt, state <= BUSY.
  - mode = 0 only: ptr <= tgt + 1 (mod 8). In mode = 1, ptr is unchanged.
- On ofire without accept: state <= IDLE, out_valid <= 0.
- Simultaneous ofire and accept: stays BUSY with the new word and lane.
  - Sustained throughput is 1 word/clk.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N, i.e. in cycle N+1.
- out_valid, out_data and cur_sel are registered. out_valid never depends combinationally on out_ready.
- Once asserted, out_valid[cur_sel] and out_data hold stable until ofire.
- xfer_cnt increments by 1 on each ofire and wraps from 2^CNT_W−1 to 0.
- Boundary conditions:
  - lane_en all zero: in_ready = 0, nothing accepted; a held word is still delivered.
  - Fixed lane disabled: in_ready = 0 (stall, no drop).
  - lane_en[cur_sel] cleared while BUSY: the committed word is still delivered to cur_sel.
  - mode or dest_sel changed while BUSY: affects only the next accept.
  - out_ready on a non-selected lane: ignored.
  - RR wrap: a pointer at 7 with lane 7 enabled selects 7, then ptr = 0.
  - Reset mid-transfer: the held word is discarded and out_valid is cleared immediately.

Decomposition:
- Shared package holds:
  - N_LANES = 8, SEL_W = 3.
  - The state typedef {IDLE, BUSY}.
  - MODE_RR = 0 and MODE_FIXED = 1 constants.
- Sub-module demux_rr_pick: combinational rotating-priority picker.
  - Inputs: mask[7:0], ptr[2:0].
  - Outputs: sel[2:0], any.
  - Reused later by other lane arbiters.

Test Plan:
- Reset mid-BUSY: assert rst_n = 0 while out_valid = 8'h04 -> out_valid = 0, xfer_cnt = 0 and ptr = 0 at once; after release, the first RR word goes to lane 0.
- RR, all lanes enabled and ready, 10 back-to-back words 0x10..0x19 -> lanes 0,1,…,7,0,1, one word per clk, in_ready stays 1, xfer_cnt = 10.
- RR with lane_en = 8'b1010_0100 and ptr = 0, 4 words -> lanes 2,5,7,2; ptr wraps correctly.
- Fixed mode, dest_sel = 6, out_ready[6] low for 5 cycles -> out_valid = 8'h40 and out_data stable; in_ready = 0 through the stall; delivered on the cycle out_ready[6] rises, with the next word accepted in the same cycle.
- Fixed mode, dest_sel = 3 with lane_en[3] = 0 -> in_ready = 0, no accept; setting lane_en[3] = 1 -> accept the next cycle.
- Clear lane_en[cur_sel] while BUSY on lane 1 -> word still delivered to lane 1; the next RR word skips lane 1; xfer_cnt at 16'hFFFF wraps to 0 on a handshake.
